bsg_cordic_hyperbolic_arbiter: RTL and testbench
================================================

// Module: bsg_cordic_hyperbolic_arbiter
// PURPOSE
//  Shares one pipelined CORDIC sinh/cosh unit among els_p requesters. Round-robin arbitration.
//  Each issued op is tagged with its requester id; results are steered back to that requester.
//  Sits between the client ports and the unit's ang/val/ready and sinh/cosh/val/ready ports.
//  Unit stalls whole-pipe when its output is valid and not accepted.
// PARAMETERS
//  els_p        4   number of requesters (>=2)
//  ang_width_p  16  angle width, passed through unchanged
//  ans_width_p  32  sinh/cosh result width
//  lat_p        16  unit latency, issue to val_o (neg_prec+posi_prec+2 for default unit)
//  max_out_p    lat_p+1  max in-flight ops = tag FIFO depth
// PORTS
//  clk_i        in   1              clock
//  reset_n_i    in   1              async active-low reset
//  v_i          in   els_p          per-requester request valid
//  ang_i        in   els_p*ang_w    per-requester angle, signed
//  ready_o      out  els_p          per-requester request accepted this cycle when v_i&ready_o
//  v_o          out  els_p          per-requester result valid (one-hot or zero)
//  sinh_o       out  ans_width_p    result sinh, shared bus, qualified by v_o
//  cosh_o       out  ans_width_p    result cosh, shared bus, qualified by v_o
//  yumi_i       in   els_p          per-requester result consume (only legal when v_o bit set)
//  cordic_ang_o / cordic_val_o      out  ang_w / 1   to unit ang_i / val_i
//  cordic_ready_i                   in   1           from unit ready_o
//  cordic_sinh_i / cordic_cosh_i    in   ans_w each  from unit
//  cordic_val_i                     in   1           from unit val_o
//  cordic_yumi_o                    out  1           to unit ready_i
// BEHAVIOUR
//  Clocking: one clock. Reset: asynchronous assert, active-low. Release is synchronised externally.
//  Reset values: ready_o=0, v_o=0, cordic_val_o=0, cordic_yumi_o=0.
//   Also: outstanding count=0, tag FIFO empty, rr pointer=els_p-1, so requester 0 wins first.
//  Issue: grant = first v_i bit searched upward from (ptr+1) mod els_p.
//   Issue allowed iff cordic_ready_i & (count<max_out_p).
//   Allowed: cordic_val_o=1, cordic_ang_o=ang_i[grant], ready_o=onehot(grant).
//   Otherwise ready_o=0, cordic_val_o=0. All of this is combinational from registered state and inputs.
//  ptr<=grant only on issue. No issue when no v_i: ptr holds.
//  Issue fires (cordic_val_o&cordic_ready_i): push grant id into tag FIFO.
//  Return: when cordic_val_i, head tag h selects the output.
//   v_o=onehot(h); sinh_o/cosh_o=cordic_*_i bitwise; cordic_yumi_o=yumi_i[h].
//   On cordic_val_i & cordic_yumi_o, pop the FIFO.
//  Requester h not consuming stalls the unit (via its ready_o), which blocks issue for all requesters.
//   This is accepted head-of-line blocking.
//  Count: +1 on issue, -1 on pop, unchanged on simultaneous issue and pop.
//   Never exceeds max_out_p, never underflows.
//  Error (assertion, sim only): cordic_val_i with FIFO empty; yumi_i bit set without matching v_o.
//  Latency: request accepted cycle t -> result v_o at t+lat_p when no stall. Full throughput: 1 op/cycle.
//  Boundary behaviour:
//   - FIFO full and pop same cycle: issue is still blocked (count check uses the registered value).
//   - ptr wraps els_p-1 -> 0.
//   - Reset mid-flight drops all tags; unit must be reset together with this block.
// STRUCTURE
//  Shared package bsg_cordic_pkg:
//   - tag width localparam `$clog2(els_p)`
//   - function cordic_hyp_latency(neg,posi)
//  Sub-module bsg_cordic_rr_arb (els_p): the round-robin pointer and grant logic.
//  Tag FIFO is inline: circular buffer with rd/wr pointers and count.
// TESTING
//  1. Single req0 ang=0x0000, yumi tied 1.
//     -> v_o=0001 exactly lat_p cycles after accept; sinh/cosh equal unit output; count back to 0.
//  2. All 4 v_i held high for 8 cycles.
//     -> grants 0,1,2,3,0,1,2,3 back-to-back; returns arrive in the same order, one per cycle.
//  3. req2 yumi held 0 for 5 cycles while reqs 0..3 stream.
//     -> pipe stalls, no issues during stall, no result lost or duplicated, order preserved.
//  4. Unit stubbed with lat_p+5 latency, continuous requests.
//     -> issue stops at count=max_out_p and resumes the cycle after the first pop.
//  5. Only req3 then req1 valid alternately.
//     -> ptr wraps 3->1 correctly; idle requesters never get ready_o.
//  6. reset_n_i low for 1 cycle with 10 ops in flight.
//     -> outputs 0 immediately; after release req0 is granted first.

Source files
------------

// File: rtl/bsg_cordic_pkg.sv
// Shared helpers for the CORDIC sinh/cosh arbiter slice.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package bsg_cordic_pkg;

  localparam int default_els_lp = 4;

  // Requester-id (tag) width for the default configuration.
  localparam int tag_width_lp = $clog2(default_els_lp);

  // Tag width for an arbitrary requester count; a single requester still
  // needs one bit so that vectors never collapse to zero width.
  function automatic int tag_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  // Issue-to-result latency of the default hyperbolic CORDIC unit: one cycle
  // per negative-precision and positive-precision stage, plus input and
  // output registers.
  function automatic int cordic_hyp_latency(input int neg_prec, input int posi_prec);
    return neg_prec + posi_prec + 2;
  endfunction

endpackage

// File: rtl/bsg_cordic_rr_arb.sv
// Round-robin grant among els_p requesters, searching upward from last winner + 1.
// Latency: grant is combinational; the pointer updates on the cycle the grant is taken.
// Backpressure: pointer holds whenever yumi_i is low, so an untaken grant is re-offered.
//
// Ports:
//   clk_i, reset_n_i   clock, async active-low reset
//   v_i                per-requester request valid
//   yumi_i             the current grant is consumed this cycle
//   grant_v_o          some requester is valid
//   grant_id_o         index of the winning requester
module bsg_cordic_rr_arb
  import bsg_cordic_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [els_p-1:0]             v_i,
  input  logic                         yumi_i,
  output logic                         grant_v_o,
  output logic [tag_width(els_p)-1:0]  grant_id_o
);

  localparam int tag_w_lp = tag_width(els_p);

  logic [tag_w_lp-1:0] ptr_q, ptr_d;
  int                  idx;

  // First valid requester strictly after the pointer, wrapping modulo els_p.
  // Ending the search at offset els_p lets the last winner win again when it
  // is the only requester.
  always_comb begin
    grant_v_o  = 1'b0;
    grant_id_o = '0;
    idx        = 0;
    for (int i = 1; i <= els_p; i++) begin
      idx = (int'(ptr_q) + i) % els_p;
      if (!grant_v_o && v_i[idx[tag_w_lp-1:0]]) begin
        grant_v_o  = 1'b1;
        grant_id_o = idx[tag_w_lp-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i) begin
      ptr_d = grant_id_o;
    end
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= tag_w_lp'(els_p - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bsg_cordic_hyperbolic_arbiter.sv
// Shares one pipelined CORDIC sinh/cosh unit among els_p requesters, steering results back by tag.
// Latency: zero added cycles; a request accepted in cycle t returns in cycle t+lat_p when not stalled.
// Backpressure: head result not consumed stalls the unit, which blocks all issue; issue also stops at max_out_p in flight.
//
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   v_i / ang_i / ready_o            per-requester request handshake and packed angles
//   v_o / sinh_o / cosh_o / yumi_i   per-requester result handshake; data buses are shared
//   cordic_ang_o / cordic_val_o      request side of the unit (cordic_ready_i from the unit)
//   cordic_sinh_i / cordic_cosh_i / cordic_val_i / cordic_yumi_o   result side of the unit
module bsg_cordic_hyperbolic_arbiter
  import bsg_cordic_pkg::*;
#(
  parameter int els_p       = 4,
  parameter int ang_width_p = 16,
  parameter int ans_width_p = 32,
  parameter int lat_p       = cordic_hyp_latency(7, 7),
  parameter int max_out_p   = lat_p + 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [els_p-1:0]              v_i,
  input  logic [els_p*ang_width_p-1:0]  ang_i,
  output logic [els_p-1:0]              ready_o,
  output logic [els_p-1:0]              v_o,
  output logic [ans_width_p-1:0]        sinh_o,
  output logic [ans_width_p-1:0]        cosh_o,
  input  logic [els_p-1:0]              yumi_i,
  output logic [ang_width_p-1:0]        cordic_ang_o,
  output logic                          cordic_val_o,
  input  logic                          cordic_ready_i,
  input  logic [ans_width_p-1:0]        cordic_sinh_i,
  input  logic [ans_width_p-1:0]        cordic_cosh_i,
  input  logic                          cordic_val_i,
  output logic                          cordic_yumi_o
);

  localparam int tag_w_lp = tag_width(els_p);
  localparam int cnt_w_lp = $clog2(max_out_p + 1);
  localparam int ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;

  logic                grant_v;
  logic [tag_w_lp-1:0] grant_id;
  logic                issue;
  logic                ret_vld;
  logic                pop;
  logic [tag_w_lp-1:0] head_tag;

  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [tag_w_lp-1:0] tag_mem [max_out_p];

  bsg_cordic_rr_arb #(
    .els_p (els_p)
  ) rr_arb (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (v_i),
    .yumi_i     (issue),
    .grant_v_o  (grant_v),
    .grant_id_o (grant_id)
  );

  // Issue side. The in-flight limit uses the registered count, so a pop in
  // the same cycle does not open a slot until the next cycle. reset_n_i gates
  // the handshake so nothing is offered while reset is held, independent of
  // what the unit and clients drive.
  always_comb begin
    issue        = reset_n_i & grant_v & cordic_ready_i &
                   (count_q < cnt_w_lp'(max_out_p));
    cordic_val_o = issue;
    cordic_ang_o = ang_i[int'(grant_id)*ang_width_p +: ang_width_p];
    ready_o      = '0;
    if (issue) begin
      ready_o[grant_id] = 1'b1;
    end
  end

  // Return side: the oldest tag owns whatever the unit presents.
  always_comb begin
    head_tag      = tag_mem[rd_ptr_q];
    ret_vld       = cordic_val_i & (count_q != '0);
    v_o           = '0;
    if (ret_vld) begin
      v_o[head_tag] = 1'b1;
    end
    cordic_yumi_o = ret_vld & yumi_i[head_tag];
    pop           = cordic_val_i & cordic_yumi_o;
    sinh_o        = cordic_sinh_i;
    cosh_o        = cordic_cosh_i;
  end

  // Circular tag buffer bookkeeping; depth need not be a power of two.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (issue && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !issue) begin
      count_d = count_q - 1'b1;
    end
    if (issue) begin
      wr_ptr_d = (wr_ptr_q == ptr_w_lp'(max_out_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == ptr_w_lp'(max_out_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      tag_mem[wr_ptr_q] <= grant_id;
    end
  end

  // Simulation-time protocol checks.
  a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(cordic_val_i && (count_q == '0)));
  a_yumi_qualified: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((yumi_i & ~v_o) == '0));
  a_count_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (count_q <= cnt_w_lp'(max_out_p)));

endmodule

// File: tb/tb_bsg_cordic_hyperbolic_arbiter.sv
`timescale 1ns/1ps
module tb_bsg_cordic_hyperbolic_arbiter;

  localparam int ELS  = 4;
  localparam int AW   = 16;
  localparam int RW   = 32;
  localparam int LAT  = 16;
  localparam int MAXO = LAT + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [ELS-1:0]    v_i, ready_o, v_o, yumi_i, yumi_mask;
  logic [ELS*AW-1:0] ang_i;
  logic [RW-1:0]     sinh_o, cosh_o, cordic_sinh_i, cordic_cosh_i;
  logic [AW-1:0]     cordic_ang_o;
  logic              cordic_val_o, cordic_ready_i, cordic_val_i, cordic_yumi_o;

  // Clients consume only what is offered to them.
  assign yumi_i = v_o & yumi_mask;

  bsg_cordic_hyperbolic_arbiter #(
    .els_p(ELS), .ang_width_p(AW), .ans_width_p(RW), .lat_p(LAT), .max_out_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .ang_i(ang_i), .ready_o(ready_o),
    .v_o(v_o), .sinh_o(sinh_o), .cosh_o(cosh_o), .yumi_i(yumi_i),
    .cordic_ang_o(cordic_ang_o), .cordic_val_o(cordic_val_o), .cordic_ready_i(cordic_ready_i),
    .cordic_sinh_i(cordic_sinh_i), .cordic_cosh_i(cordic_cosh_i),
    .cordic_val_i(cordic_val_i), .cordic_yumi_o(cordic_yumi_o)
  );

  // Stand-in unit results: cheap, invertible tags of the angle.
  function automatic logic [RW-1:0] f_sinh(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction
  function automatic logic [RW-1:0] f_cosh(input logic [AW-1:0] a);
    return {a ^ 16'h1234, a};
  endfunction

  // Unit stub: stub_lat-deep pipe that freezes entirely while its output is
  // valid and not taken.
  int            stub_lat = LAT;
  logic [31:0]   st_v;
  logic [AW-1:0] st_ang [32];
  assign cordic_val_i   = st_v[stub_lat-1];
  assign cordic_ready_i = !(cordic_val_i && !cordic_yumi_o);
  assign cordic_sinh_i  = f_sinh(st_ang[stub_lat-1]);
  assign cordic_cosh_i  = f_cosh(st_ang[stub_lat-1]);
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_v <= '0;
    end else if (cordic_ready_i) begin
      st_v      <= {st_v[30:0], cordic_val_o};
      st_ang[0] <= cordic_ang_o;
      for (int i = 1; i < 32; i++) st_ang[i] <= st_ang[i-1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ordered list of in-flight (requester, angle) pairs plus a
  // round-robin pointer; its length is the outstanding count.
  int            m_ptr;
  int            q_id[$];
  logic [AW-1:0] q_ang[$];
  int            glog[$], gcyc[$], rlog[$], rcyc[$];
  int            n_iss = 0;
  int            n_ret = 0;

  always @(negedge clk) begin
    int             eg, h, idx;
    logic           ei;
    logic [ELS-1:0] er;
    if (!reset_n) begin
      m_ptr = ELS - 1;
      q_id.delete();
      q_ang.delete();
      chk("rst_ready_o", 64'(ready_o), 64'(0));
      chk("rst_v_o", 64'(v_o), 64'(0));
      chk("rst_cordic_val_o", 64'(cordic_val_o), 64'(0));
      chk("rst_cordic_yumi_o", 64'(cordic_yumi_o), 64'(0));
    end else begin
      eg = -1;
      for (int i = 1; i <= ELS; i++) begin
        idx = (m_ptr + i) % ELS;
        if (eg < 0 && v_i[idx[1:0]]) eg = idx;
      end
      ei = (eg >= 0) && cordic_ready_i && (q_id.size() < MAXO);
      er = '0;
      if (ei) er[eg[1:0]] = 1'b1;
      chk("issue_ready_o", 64'(ready_o), 64'(er));
      chk("issue_cordic_val_o", 64'(cordic_val_o), 64'(ei));
      if (ei) chk("issue_ang", 64'(cordic_ang_o), 64'(ang_i[eg*AW +: AW]));

      if (cordic_val_i) begin
        n_chk++;
        if (q_id.size() == 0) begin
          n_fail++;
          $display("FAIL ret_orphan: unit result with no request outstanding (cycle %0d)", cyc);
        end else begin
          h  = q_id[0];
          er = '0;
          er[h[1:0]] = 1'b1;
          chk("ret_v_o", 64'(v_o), 64'(er));
          chk("ret_sinh", 64'(sinh_o), 64'(f_sinh(q_ang[0])));
          chk("ret_cosh", 64'(cosh_o), 64'(f_cosh(q_ang[0])));
          chk("ret_cordic_yumi", 64'(cordic_yumi_o), 64'(yumi_mask[h[1:0]]));
          if (yumi_mask[h[1:0]]) begin
            void'(q_id.pop_front());
            void'(q_ang.pop_front());
          end
        end
      end else begin
        chk("idle_v_o", 64'(v_o), 64'(0));
        chk("idle_cordic_yumi", 64'(cordic_yumi_o), 64'(0));
      end

      if (ei) begin
        q_id.push_back(eg);
        q_ang.push_back(ang_i[eg*AW +: AW]);
        m_ptr = eg;
      end

      for (int i = 0; i < ELS; i++) begin
        if (ready_o[i] && v_i[i]) begin glog.push_back(i); gcyc.push_back(cyc); n_iss++; end
        if (v_o[i] && yumi_i[i])  begin rlog.push_back(i); rcyc.push_back(cyc); n_ret++; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ang();
    ang_i = {$urandom, $urandom};
  endtask

  task automatic do_reset(input int lat);
    reset_n   = 1'b0;
    v_i       = '0;
    yumi_mask = '1;
    stub_lat  = lat;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    v_i       = '0;
    yumi_mask = '1;
    k = 0;
    while (q_id.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk({name, "_drained"}, 64'(q_id.size()), 64'(0));
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k, cnt, iss0, ret0, hold, stall_iss;
    v_i = '0; ang_i = '0; yumi_mask = '1;
    do_reset(LAT);

    // 1: single request from requester 0, zero angle.
    ang_i = '0;
    v_i   = 4'b0001;
    @(negedge clk);
    t0 = cyc;
    chk("t1_accept", 64'(ready_o), 64'(4'b0001));
    tick();
    v_i = '0;
    k = 0;
    while (!v_o[0] && k < 40) begin @(negedge clk); k++; end
    chk("t1_latency", 64'(cyc - t0), 64'(16));
    chk("t1_v_o", 64'(v_o), 64'(4'b0001));
    chk("t1_sinh", 64'(sinh_o), 64'(32'h0000FFFF));
    chk("t1_cosh", 64'(cosh_o), 64'(32'h12340000));
    drain("t1");

    // 2: all four requesters for 8 cycles.
    do_reset(LAT);
    glog.delete(); rlog.delete(); rcyc.delete();
    v_i = 4'hF;
    repeat (8) begin rand_ang(); tick(); end
    drain("t2");
    chk("t2_grant_count", 64'(glog.size()), 64'(8));
    chk("t2_return_count", 64'(rlog.size()), 64'(8));
    if (glog.size() == 8 && rlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_grant_order", 64'(glog[i]), 64'(i % 4));
        chk("t2_return_order", 64'(rlog[i]), 64'(i % 4));
      end
      chk("t2_return_span", 64'(rcyc[7] - rcyc[0]), 64'(7));
    end

    // 3: requester 2 withholds yumi for 5 cycles while everyone streams.
    do_reset(LAT);
    iss0 = n_iss; ret0 = n_ret; hold = 0; stall_iss = 0;
    v_i = 4'hF;
    yumi_mask = 4'b1011;
    for (int j = 0; j < 80; j++) begin
      rand_ang();
      if (hold == 5) yumi_mask = 4'hF;
      @(negedge clk);
      if (v_o[2] && !yumi_mask[2]) begin
        hold++;
        if (cordic_val_o) stall_iss++;
      end
      tick();
    end
    chk("t3_stall_cycles", 64'(hold), 64'(5));
    chk("t3_issue_during_stall", 64'(stall_iss), 64'(0));
    drain("t3");
    chk("t3_no_loss", 64'(n_ret - ret0), 64'(n_iss - iss0));

    // 4: slower unit, in-flight limit reached.
    do_reset(LAT + 5);
    gcyc.delete();
    v_i = 4'hF;
    repeat (30) begin rand_ang(); tick(); end
    cnt = 0;
    foreach (gcyc[j]) if (gcyc[j] - gcyc[0] <= 21) cnt++;
    chk("t4_issues_before_pop", 64'(cnt), 64'(17));
    if (gcyc.size() > 17) begin
      chk("t4_resume_cycle", 64'(gcyc[17] - gcyc[0]), 64'(22));
    end else begin
      n_chk++; n_fail++;
      $display("FAIL t4_resume_cycle: only %0d issues seen, required more than 17", gcyc.size());
    end
    drain("t4");

    // 5: only requesters 3 and 1 valid.
    do_reset(LAT);
    glog.delete();
    v_i = 4'b1010;
    repeat (6) begin rand_ang(); tick(); end
    drain("t5");
    chk("t5_grant_count", 64'(glog.size()), 64'(6));
    if (glog.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_grant_order", 64'(glog[i]), 64'((i % 2 == 0) ? 1 : 3));
    end

    // 6: reset with 10 ops in flight.
    do_reset(LAT);
    glog.delete();
    v_i = 4'hF;
    repeat (10) begin rand_ang(); tick(); end
    chk("t6_inflight", 64'(glog.size()), 64'(10));
    reset_n = 1'b0;
    #1;
    chk("t6_ready_in_reset", 64'(ready_o), 64'(0));
    chk("t6_cval_in_reset", 64'(cordic_val_o), 64'(0));
    chk("t6_v_o_in_reset", 64'(v_o), 64'(0));
    tick();
    reset_n = 1'b1;
    glog.delete();
    repeat (3) tick();
    chk("t6_first_after_reset", 64'((glog.size() > 0) ? glog[0] : -1), 64'(0));
    drain("t6");

    // Random traffic with random consumer stalls.
    do_reset(LAT);
    iss0 = n_iss; ret0 = n_ret;
    repeat (400) begin
      v_i       = ELS'($urandom);
      yumi_mask = ELS'($urandom | $urandom);
      rand_ang();
      tick();
    end
    drain("rand");
    chk("rand_no_loss", 64'(n_ret - ret0), 64'(n_iss - iss0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
